// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, cause codes,
// mstatus bit positions and the FSM/context encodings.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MSTATUS = 3'd2,
    S_W_MCAUSE  = 3'd3,
    S_JUMP      = 3'd4,
    S_MRET_ST   = 3'd5,
    S_MRET_JUMP = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_EXC  = 2'd1,
    K_IRQ  = 2'd2,
    K_MRET = 2'd3
  } kind_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Pipeline <-> trap sequencer bundle: EX-stage events and CSR taps in,
// CSR write port, stall and fetch redirect out.
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] inst_addr;
  logic            ecall;
  logic            ebreak;
  logic            mret;
  logic            int_req;
  logic            glb_int_en;
  logic [XLEN-1:0] csr_mtvec;
  logic [XLEN-1:0] csr_mepc;
  logic [XLEN-1:0] csr_mstatus;
  logic            csr_wren;
  logic [11:0]     csr_wraddr;
  logic [XLEN-1:0] csr_wrdata;
  logic            hold_req;
  logic            jump_en;
  logic [XLEN-1:0] jump_addr;

  modport master (
    output inst_addr, ecall, ebreak, mret, int_req, glb_int_en,
           csr_mtvec, csr_mepc, csr_mstatus,
    input  csr_wren, csr_wraddr, csr_wrdata, hold_req, jump_en, jump_addr
  );

  modport slave (
    input  inst_addr, ecall, ebreak, mret, int_req, glb_int_en,
           csr_mtvec, csr_mepc, csr_mstatus,
    output csr_wren, csr_wraddr, csr_wrdata, hold_req, jump_en, jump_addr
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer: stalls the pipeline, writes mepc/mstatus/mcause
// one per cycle, then redirects fetch to mtvec (trap) or mepc (mret).
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] INT_CAUSE = 32'h8000_000B,
  parameter int              VECTORED  = 0
) (
  input logic          clk,
  input logic          rst,
  trap_ctrl_if.slave   bus
);

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [XLEN-1:0] epc_q, cause_q, cause_d;
  logic            ctx_ld;
  logic            ev_any;
  logic [XLEN-1:0] mtvec_base;

  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r               = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r               = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

  assign ev_any     = bus.ecall | bus.ebreak | bus.mret | (bus.int_req & bus.glb_int_en);
  assign mtvec_base = bus.csr_mtvec & ~XLEN'(3);

  // Accept is gated by rst so every output reads 0 while reset is held.
  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    cause_d        = cause_q;
    ctx_ld         = 1'b0;
    bus.csr_wren   = 1'b0;
    bus.csr_wraddr = '0;
    bus.csr_wrdata = '0;
    bus.hold_req   = 1'b0;
    bus.jump_en    = 1'b0;
    bus.jump_addr  = '0;
    case (state_q)
      S_IDLE: begin
        if (rst && ev_any) begin
          bus.hold_req = 1'b1;
          ctx_ld       = 1'b1;
          state_d      = S_W_MEPC;
          if (bus.ecall) begin
            cause_d = XLEN'(CAUSE_ECALL);
            kind_d  = K_EXC;
          end else if (bus.ebreak) begin
            cause_d = XLEN'(CAUSE_EBREAK);
            kind_d  = K_EXC;
          end else if (bus.mret) begin
            kind_d  = K_MRET;
            state_d = S_MRET_ST;
          end else begin
            cause_d = INT_CAUSE;
            kind_d  = K_IRQ;
          end
        end
      end
      S_W_MEPC: begin
        bus.hold_req   = 1'b1;
        bus.csr_wren   = 1'b1;
        bus.csr_wraddr = CSR_MEPC;
        bus.csr_wrdata = epc_q;
        state_d        = S_W_MSTATUS;
      end
      // mstatus is taken live here so an EX write in the accept cycle is seen.
      S_W_MSTATUS: begin
        bus.hold_req   = 1'b1;
        bus.csr_wren   = 1'b1;
        bus.csr_wraddr = CSR_MSTATUS;
        bus.csr_wrdata = mstatus_on_trap(bus.csr_mstatus);
        state_d        = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        bus.hold_req   = 1'b1;
        bus.csr_wren   = 1'b1;
        bus.csr_wraddr = CSR_MCAUSE;
        bus.csr_wrdata = cause_q;
        state_d        = S_JUMP;
      end
      S_JUMP: begin
        bus.hold_req = 1'b1;
        bus.jump_en  = 1'b1;
        if ((VECTORED != 0) && (kind_q == K_IRQ))
          bus.jump_addr = mtvec_base + {INT_CAUSE[XLEN-3:0], 2'b00};
        else
          bus.jump_addr = mtvec_base;
        state_d = S_IDLE;
      end
      S_MRET_ST: begin
        bus.hold_req   = 1'b1;
        bus.csr_wren   = 1'b1;
        bus.csr_wraddr = CSR_MSTATUS;
        bus.csr_wrdata = mstatus_on_mret(bus.csr_mstatus);
        state_d        = S_MRET_JUMP;
      end
      S_MRET_JUMP: begin
        bus.hold_req  = 1'b1;
        bus.jump_en   = 1'b1;
        bus.jump_addr = bus.csr_mepc;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epc_q   <= '0;
      cause_q <= '0;
      kind_q  <= K_NONE;
    end else if (ctx_ld) begin
      epc_q   <= bus.inst_addr;
      cause_q <= cause_d;
      kind_q  <= kind_d;
    end
  end

endmodule
